// File: rtl/cpu_trace_emitter.sv
// rtl/cpu_trace_emitter.sv - serialises CPU write events into the ASCII trace character stream
module cpu_trace_emitter #(
   parameter int unsigned TIME_MAX = 9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_op,
   input  logic [13:0] in_time,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_reg,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   output logic [7:0]  char_out,
   output logic        char_valid,
   input  logic        char_ready,
   output logic        done
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CARET,
      S_TIME,
      S_AT,
      S_PC,
      S_COLON,
      S_SP1,
      S_SIGIL,
      S_ARG,
      S_SP2,
      S_LT,
      S_EQ,
      S_SP3,
      S_DATA,
      S_HASH
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] time_bcd_q, time_bcd_d;
   logic [7:0]  reg_bcd_q, reg_bcd_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        op_q, op_d;
   logic [7:0]  char_out_q, char_out_d;
   logic        char_valid_q, char_valid_d;
   logic        in_ready_q, in_ready_d;
   logic        done_q, done_d;

   logic        xfer;
   logic [13:0] time_clamped;
   logic [3:0]  time_len_m1;
   logic [3:0]  reg_len_m1;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   function automatic logic [3:0] nib(input logic [31:0] w, input logic [2:0] i);
      return w[{i, 2'b00} +: 4];
   endfunction

   // Shift-and-add-3 conversion; inputs are bounded to 9999 so four BCD digits suffice.
   function automatic logic [15:0] bin2bcd(input logic [13:0] b);
      logic [29:0] s;
      s = {16'd0, b};
      for (int i = 0; i < 14; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (s[14 + 4*j +: 4] >= 4'd5)
               s[14 + 4*j +: 4] = s[14 + 4*j +: 4] + 4'd3;
         end
         s = s << 1;
      end
      return s[29:14];
   endfunction

   assign xfer = char_valid_q && char_ready;

   always_comb begin
      time_clamped = (in_time > 14'(TIME_MAX)) ? 14'(TIME_MAX) : in_time;

      if (time_bcd_q[15:12] != 4'd0)
         time_len_m1 = 4'd3;
      else if (time_bcd_q[11:8] != 4'd0)
         time_len_m1 = 4'd2;
      else if (time_bcd_q[7:4] != 4'd0)
         time_len_m1 = 4'd1;
      else
         time_len_m1 = 4'd0;

      reg_len_m1 = (reg_bcd_q[7:4] != 4'd0) ? 4'd1 : 4'd0;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      time_bcd_d = time_bcd_q;
      reg_bcd_d  = reg_bcd_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      data_d     = data_q;
      op_d       = op_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               time_bcd_d = bin2bcd(time_clamped);
               reg_bcd_d  = 8'(bin2bcd({9'd0, in_reg}));
               pc_d       = in_pc;
               addr_d     = in_addr;
               data_d     = in_data;
               op_d       = in_op;
               cnt_d      = 4'd0;
               state_d    = S_CARET;
            end
         end
         S_CARET: if (xfer) begin
            state_d = S_TIME;
            cnt_d   = time_len_m1;
         end
         S_TIME: if (xfer) begin
            if (cnt_q == 4'd0) state_d = S_AT;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_AT: if (xfer) begin
            state_d = S_PC;
            cnt_d   = 4'd7;
         end
         S_PC: if (xfer) begin
            if (cnt_q == 4'd0) state_d = S_COLON;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_COLON: if (xfer) state_d = S_SP1;
         S_SP1:   if (xfer) state_d = S_SIGIL;
         S_SIGIL: if (xfer) begin
            state_d = S_ARG;
            cnt_d   = op_q ? 4'd7 : reg_len_m1;
         end
         S_ARG: if (xfer) begin
            if (cnt_q == 4'd0) state_d = S_SP2;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_SP2: if (xfer) state_d = S_LT;
         S_LT:  if (xfer) state_d = S_EQ;
         S_EQ:  if (xfer) state_d = S_SP3;
         S_SP3: if (xfer) begin
            state_d = S_DATA;
            cnt_d   = 4'd7;
         end
         S_DATA: if (xfer) begin
            if (cnt_q == 4'd0) state_d = S_HASH;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_HASH: if (xfer) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered, so the character is chosen from the state being entered.
   always_comb begin
      in_ready_d   = (state_d == S_IDLE);
      char_valid_d = (state_d != S_IDLE);
      case (state_d)
         S_CARET: char_out_d = 8'h5e;
         S_TIME:  char_out_d = 8'h30 + {4'h0, time_bcd_q[{cnt_d[1:0], 2'b00} +: 4]};
         S_AT:    char_out_d = 8'h40;
         S_PC:    char_out_d = hex_char(nib(pc_q, cnt_d[2:0]));
         S_COLON: char_out_d = 8'h3a;
         S_SP1:   char_out_d = 8'h20;
         S_SIGIL: char_out_d = op_q ? 8'h2a : 8'h24;
         S_ARG:   char_out_d = op_q ? hex_char(nib(addr_q, cnt_d[2:0]))
                                    : 8'h30 + {4'h0, reg_bcd_q[{cnt_d[0], 2'b00} +: 4]};
         S_SP2:   char_out_d = 8'h20;
         S_LT:    char_out_d = 8'h3c;
         S_EQ:    char_out_d = 8'h3d;
         S_SP3:   char_out_d = 8'h20;
         S_DATA:  char_out_d = hex_char(nib(data_q, cnt_d[2:0]));
         S_HASH:  char_out_d = 8'h23;
         default: char_out_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         time_bcd_q   <= 16'd0;
         reg_bcd_q    <= 8'd0;
         pc_q         <= 32'd0;
         addr_q       <= 32'd0;
         data_q       <= 32'd0;
         op_q         <= 1'b0;
         char_out_q   <= 8'h00;
         char_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         time_bcd_q   <= time_bcd_d;
         reg_bcd_q    <= reg_bcd_d;
         pc_q         <= pc_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         op_q         <= op_d;
         char_out_q   <= char_out_d;
         char_valid_q <= char_valid_d;
         in_ready_q   <= in_ready_d;
         done_q       <= done_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign char_out   = char_out_q;
   assign char_valid = char_valid_q;
   assign done       = done_q;

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// tb/tb_cpu_trace_emitter.sv - directed self-checking bench for cpu_trace_emitter
module tb_cpu_trace_emitter;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_op;
   logic [13:0] in_time;
   logic [31:0] in_pc;
   logic [4:0]  in_reg;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [7:0]  char_out;
   logic        char_valid;
   logic        char_ready;
   logic        done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   cpu_trace_emitter #(.TIME_MAX(9999)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_time    (in_time),
      .in_pc      (in_pc),
      .in_reg     (in_reg),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .char_out   (char_out),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .done       (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_event(input logic op, input logic [13:0] t, input logic [31:0] pc,
                              input logic [4:0] rg, input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      in_op    = op;
      in_time  = t;
      in_pc    = pc;
      in_reg   = rg;
      in_addr  = addr;
      in_data  = data;
      in_valid = 1'b1;
   endtask

   task automatic collect(input string tag, input string exp, input bit rnd, input bit hold_in,
                          output int first_x, output int last_x);
      int idx;
      int guard;
      bit stalled;
      logic [7:0] prev;
      idx = 0;
      guard = 0;
      stalled = 1'b0;
      prev = 8'h00;
      first_x = -1;
      last_x = -1;
      while (idx < exp.len() && guard < 400) begin
         @(negedge clk);
         guard++;
         if (!hold_in) in_valid = 1'b0;
         if (stalled)
            chk({tag, " hold"}, {23'd0, char_valid, char_out}, {23'd0, 1'b1, prev});
         if (char_valid) begin
            chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
            char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (char_ready) begin
               chk($sformatf("%s char%0d", tag, idx), 32'(char_out), 32'(exp[idx]));
               if (idx == 0) first_x = cyc + 1;
               if (idx == exp.len() - 1) last_x = cyc + 1;
               idx++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               prev = char_out;
            end
         end else begin
            char_ready = 1'b0;
            stalled = 1'b0;
         end
      end
      if (idx < exp.len()) chk({tag, " timeout"}, 32'(idx), 32'(exp.len()));
      @(negedge clk);
      char_ready = 1'b0;
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " idle valid"}, 32'(char_valid), 32'd0);
      chk({tag, " idle ready"}, 32'(in_ready), 32'd1);
      if (!hold_in) begin
         @(negedge clk);
         chk({tag, " done pulse"}, 32'(done), 32'd0);
      end
   endtask

   initial begin
      int fx;
      int lx;
      int fx2;
      int lx2;
      int n;
      int guard;
      string rec1;
      string rec2;
      string rec3;
      string rec4;
      rec1 = "^12@00003000: $5 <= 0000000a#";
      rec2 = "^0@00003004: *00000010 <= deadbeef#";
      rec3 = "^9999@ffffffff: $0 <= 12345678#";
      rec4 = "^1000@00000000: $31 <= ffffffff#";

      reset = 1'b0;
      in_valid = 1'b0;
      char_ready = 1'b0;
      in_op = 1'b0;
      in_time = '0;
      in_pc = '0;
      in_reg = '0;
      in_addr = '0;
      in_data = '0;

      repeat (2) @(negedge clk);
      chk("reset char_valid", 32'(char_valid), 32'd0);
      chk("reset char_out", 32'(char_out), 32'h00);
      chk("reset done", 32'(done), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      reset = 1'b1;
      char_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle ready ignored", {30'd0, char_valid, in_ready}, 32'd1);
      char_ready = 1'b0;

      start_event(1'b0, 14'd12, 32'h00003000, 5'd5, 32'h0, 32'h0000000a);
      collect("reg", rec1, 1'b0, 1'b0, fx, lx);
      chk("reg length", 32'(lx - fx + 1), 32'd29);

      start_event(1'b1, 14'd0, 32'h00003004, 5'd17, 32'h00000010, 32'hdeadbeef);
      collect("mem", rec2, 1'b0, 1'b0, fx, lx);
      chk("mem length", 32'(lx - fx + 1), 32'd35);

      start_event(1'b0, 14'd10000, 32'hffffffff, 5'd0, 32'h0, 32'h12345678);
      collect("clamp", rec3, 1'b0, 1'b0, fx, lx);

      start_event(1'b0, 14'd1000, 32'h00000000, 5'd31, 32'h0, 32'hffffffff);
      collect("reg31", rec4, 1'b0, 1'b0, fx, lx);

      start_event(1'b0, 14'd12, 32'h00003000, 5'd5, 32'h0, 32'h0000000a);
      collect("bp", rec1, 1'b1, 1'b0, fx, lx);

      start_event(1'b0, 14'd12, 32'h00003000, 5'd5, 32'h0, 32'h0000000a);
      n = 0;
      guard = 0;
      while (n < 10 && guard < 100) begin
         @(negedge clk);
         guard++;
         in_valid = 1'b0;
         char_ready = 1'b1;
         if (char_valid) n++;
      end
      chk("rst reach10", 32'(n), 32'd10);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rst char_valid", 32'(char_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst char_out", 32'(char_out), 32'h00);
      char_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst stays idle", 32'(char_valid), 32'd0);
      start_event(1'b1, 14'd0, 32'h00003004, 5'd3, 32'h00000010, 32'hdeadbeef);
      collect("post rst", rec2, 1'b0, 1'b0, fx, lx);

      start_event(1'b0, 14'd12, 32'h00003000, 5'd5, 32'h0, 32'h0000000a);
      @(posedge clk);
      #2;
      in_time = 14'd1000;
      in_pc = 32'h00000000;
      in_reg = 5'd31;
      in_data = 32'hffffffff;
      collect("b2b A", rec1, 1'b0, 1'b1, fx, lx);
      collect("b2b B", rec4, 1'b0, 1'b0, fx2, lx2);
      chk("b2b gap", 32'(fx2 - lx), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cpu_trace_emitter.md
Name: cpu_trace_emitter

Overview:
- Generates the CPU write-trace text stream, one ASCII character per transfer, from binary write-event fields.
- Register-write form: `^<time>@<pc>: $<reg> <= <data>#`.
- Memory-write form: `^<time>@<pc>: *<addr> <= <data>#`.
- Sits at the CPU's trace output and drives the character-stream format checker. Its output must always be classified as a valid type 01 (register) or type 10 (memory) record.

Parameters:
- TIME_MAX, 9999: largest printable time value. Larger inputs clamp to this value.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  write event offered
- in_ready  out  1  emitter can accept an event (high only in IDLE)
- in_op  in  1  0 = register write, 1 = memory write
- in_time  in  14  cycle stamp, unsigned
- in_pc  in  32  instruction address
- in_reg  in  5  register number (used when in_op=0)
- in_addr  in  32  memory address (used when in_op=1)
- in_data  in  32  written value
- char_out  out  8  ASCII character
- char_valid  out  1  char_out holds a valid character
- char_ready  in  1  sink accepts char_out this cycle
- done  out  1  one-cycle pulse after the final '#' is accepted

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, char_valid=0, char_out=8'h00, done=0, in_ready=1.
  - All field registers cleared.
  - Applies at any point, including mid-record. No partial record resumes after release.
- Accept: in_valid && in_ready at a clock edge.
  - Latch all fields, converting to BCD/digit registers at this edge.
  - in_time is clamped to TIME_MAX first.
  - Next cycle: char_valid=1, char_out="^", in_ready=0.
- Character transfer:
  - A character is consumed on any edge with char_valid && char_ready. The emitter then advances to the next character with no bubbles.
  - While char_valid && !char_ready, char_out and char_valid hold stable.
  - char_valid stays 1 from "^" through "#".
- Emission states, in order:
  - CARET: "^"
  - TIME: decimal, no leading zeros, 1–4 digits; 0 prints "0"
  - AT: "@"
  - PC: 8 lowercase hex digits, MSB first
  - COLON: ":"
  - SP1: " "
  - SIGIL: "$" if op=0, "*" if op=1
  - ARG:
    - op=0: in_reg in decimal, no leading zeros, 1–2 digits
    - op=1: in_addr as 8 lowercase hex digits
  - SP2: " "
  - LT: "<"
  - EQ: "="
  - SP3: " "
  - DATA: 8 lowercase hex digits
  - HASH: "#"
- Digit counting: a 4-bit counter runs in the multi-digit states.
  - Loaded with (digit count − 1) on entry.
  - Decremented per transfer; the state exits when it reaches 0 on a transfer.
- Hex mapping: 0–9 map to 8'h30–8'h39; a–f map to 8'h61–8'h66.
- Record length: 26 + T + R characters.
  - T = number of time digits.
  - R = register-number digits (op=0) or 8 (op=1).
- End of record:
  - On the edge accepting "#": go to IDLE, char_valid←0, done←1 for exactly one cycle, in_ready←1.
  - A new event can therefore be accepted on the following edge. Records are back-to-back with a 1-cycle gap minimum.
- in_valid while busy is ignored (no latching). Input fields may change freely after acceptance.
- char_ready while char_valid=0 has no effect.

Test Plan:
- Register record: time=12, pc=0x00003000, op=0, reg=5, data=0x0000000a, char_ready=1 → exactly 29 chars "^12@00003000: $5 <= 0000000a#". done pulses 1 cycle after "#". in_ready low throughout.
- Memory record: time=0, pc=0x00003004, op=1, addr=0x00000010, data=0xdeadbeef → 35 chars "^0@00003004: *00000010 <= deadbeef#".
- Boundaries:
  - time=10000 → "9999".
  - time=1000 → "1000".
  - reg=0 → "$0".
  - reg=31 → "$31".
  - pc=0xffffffff → "ffffffff".
- Backpressure: random char_ready (≈50% duty) on the register record → identical 29-char sequence. char_out is stable every stalled cycle. No drops or duplicates.
- Reset mid-record: assert reset asynchronously (off clock edge) after the 10th char → char_valid=0 and in_ready=1 immediately. Next accepted event emits a full record starting with "^".
- Back-to-back: in_valid held high with 2 events → second "^" appears exactly 2 cycles after the first "#" transfer. Busy-time in_valid changes do not corrupt the record.
